projectile_grid: RTL and testbench

Parametrised projectile field for the Starflux play area. It holds two bit-planes of COLS×ROWS cells: player shots travelling up and enemy shots travelling down. The planes advance one row per `gridUpdateEn` step. The block detects shot-vs-shot cancellation and shot-vs-ship hits, rate-limits player fire, and keeps a saturating hit score. It sits between the input/enemy controllers and the VGA renderer, which reads `grid`.

---
 rtl/projectile_grid.sv | 155 +++++++++++++++
 tb/tb_projectile_grid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_grid.sv
// projectile_grid: two shot planes (player shots rise, enemy shots fall) advanced one
// row per step, with shot-vs-shot cancellation, shot-vs-ship hits, a player fire
// cooldown and a saturating hit score.
module projectile_grid #(
  parameter int COLS       = 160,
  parameter int ROWS       = 120,
  parameter int XW         = 8,
  parameter int PLAYER_ROW = 112,
  parameter int ENEMY_ROW  = 8,
  parameter int COOLDOWN   = 4,
  parameter int SCW        = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 gridUpdateEn,
  input  logic                 shoot,
  input  logic                 enemy_fire,
  input  logic [XW-1:0]        user_x,
  input  logic [XW-1:0]        enemy_x,
  output logic [COLS*ROWS-1:0] grid,
  output logic [COLS*ROWS-1:0] player_shots,
  output logic [COLS*ROWS-1:0] enemy_shots,
  output logic                 enemy_hit,
  output logic                 player_hit,
  output logic [SCW-1:0]       hit_count
);

  localparam int N   = COLS * ROWS;
  localparam int CDW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CDW-1:0] CD_LOAD   = CDW'(COOLDOWN);
  localparam logic [XW:0]    COLS_LIM  = (XW + 1)'(COLS);
  localparam logic [SCW-1:0] SCORE_MAX = '1;

  logic [N-1:0]    p_plane, e_plane;
  logic [N-1:0]    p_next, e_next;
  logic [COLS-1:0] enemy_hit_col, player_hit_col;
  logic            pp, ep, shoot_q;
  logic [CDW-1:0]  cooldown;
  logic            shoot_rise, pp_eff, ep_eff, user_in, inject_p, inject_e;

  // A request arriving together with a step is served by that step.
  assign shoot_rise = shoot & ~shoot_q;
  assign pp_eff     = pp | shoot_rise;
  assign ep_eff     = ep | enemy_fire;
  assign user_in    = {1'b0, user_x} < COLS_LIM;
  assign inject_p   = pp_eff & (cooldown == '0) & user_in;
  assign inject_e   = ep_eff;

  assign grid         = p_plane | e_plane;
  assign player_shots = p_plane;
  assign enemy_shots  = e_plane;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS-1:0] pcol, ecol, ks;
    logic [ROWS-1:1] kc;
    logic [ROWS-1:2] kf;
    logic            user_here, enemy_here;

    assign pcol       = p_plane[c*ROWS +: ROWS];
    assign ecol       = e_plane[c*ROWS +: ROWS];
    assign user_here  = (user_x == XW'(c));
    assign enemy_here = (enemy_x == XW'(c));

    // Greedy pairing from the top of the column: a player shot takes the nearest
    // enemy at r, r-1, r-2 that the player shots above it have not already taken.
    for (genvar r = 0; r < ROWS; r++) begin : g_kill
      assign ks[r] = pcol[r] & ecol[r];
      if (r >= 1) begin : g_cross
        assign kc[r] = pcol[r] & ~ecol[r] & ecol[r-1] & ~pcol[r-1];
      end
      if (r >= 2) begin : g_far
        assign kf[r] = pcol[r] & ~ecol[r] & ~(ecol[r-1] & ~pcol[r-1])
                     & ecol[r-2] & ~pcol[r-2] & ~(pcol[r-1] & ~ecol[r-1]);
      end
    end

    // Movement of survivors, then ship hits, then injection of new shots.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic p_in, e_in;

      if (r == ROWS - 1) begin : g_p_top
        assign p_in = 1'b0;
      end else if (r == 0) begin : g_p_zero
        assign p_in = pcol[1] & ~(ks[1] | kc[1]);
      end else begin : g_p_mid
        assign p_in = pcol[r+1] & ~(ks[r+1] | kc[r+1] | kf[r+1]);
      end

      if (r == 0) begin : g_e_zero
        assign e_in = 1'b0;
      end else if (r == ROWS - 1) begin : g_e_last
        assign e_in = ecol[r-1] & ~(ks[r-1] | kc[r]);
      end else begin : g_e_mid
        assign e_in = ecol[r-1] & ~(ks[r-1] | kc[r] | kf[r+1]);
      end

      if (r == ENEMY_ROW) begin : g_p_ship
        assign p_next[c*ROWS+r]  = p_in & ~enemy_here;
        assign enemy_hit_col[c]  = p_in & enemy_here;
      end else if (r == PLAYER_ROW - 1) begin : g_p_inj
        assign p_next[c*ROWS+r]  = p_in | (inject_p & user_here);
      end else begin : g_p_pass
        assign p_next[c*ROWS+r]  = p_in;
      end

      if (r == PLAYER_ROW) begin : g_e_ship
        assign e_next[c*ROWS+r]  = e_in & ~user_here;
        assign player_hit_col[c] = e_in & user_here;
      end else if (r == ENEMY_ROW + 1) begin : g_e_inj
        assign e_next[c*ROWS+r]  = e_in | (inject_e & enemy_here);
      end else begin : g_e_pass
        assign e_next[c*ROWS+r]  = e_in;
      end
    end
  end

  // Planes, pending requests, cooldown, hit pulses and score; reset wins over a step.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_plane    <= '0;
      e_plane    <= '0;
      pp         <= 1'b0;
      ep         <= 1'b0;
      shoot_q    <= 1'b0;
      cooldown   <= '0;
      enemy_hit  <= 1'b0;
      player_hit <= 1'b0;
      hit_count  <= '0;
    end else begin
      shoot_q    <= shoot;
      enemy_hit  <= 1'b0;
      player_hit <= 1'b0;
      if (enemy_hit && hit_count != SCORE_MAX) begin
        hit_count <= hit_count + 1'b1;
      end
      if (gridUpdateEn) begin
        p_plane    <= p_next;
        e_plane    <= e_next;
        enemy_hit  <= |enemy_hit_col;
        player_hit <= |player_hit_col;
        ep         <= 1'b0;
        pp         <= pp_eff & (cooldown != '0);
        if (inject_p) begin
          cooldown <= CD_LOAD;
        end else if (cooldown != '0) begin
          cooldown <= cooldown - 1'b1;
        end
      end else begin
        pp <= pp_eff;
        ep <= ep_eff;
      end
    end
  end

endmodule

// File: tb/tb_projectile_grid.sv
// tb_projectile_grid: directed vectors with hand-computed expectations for projectile_grid
// on an 8x16 field (player row 14, enemy row 1, cooldown 2).
module tb_projectile_grid;

  localparam int COLS = 8;
  localparam int ROWS = 16;
  localparam int XW   = 4;
  localparam int PR   = 14;
  localparam int ER   = 1;
  localparam int CD   = 2;
  localparam int SCW  = 8;

  logic           clock, reset, gridUpdateEn, shoot, enemyFire;
  logic [XW-1:0]  userX, enemyX;
  logic [127:0]   grid, playerShots, enemyShots;
  logic           enemyHit, playerHit;
  logic [SCW-1:0] hitCount;

  int errorCount = 0;
  int checkCount = 0;

  projectile_grid #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .PLAYER_ROW(PR),
    .ENEMY_ROW(ER), .COOLDOWN(CD), .SCW(SCW)
  ) dut (
    .clock(clock), .reset(reset), .gridUpdateEn(gridUpdateEn),
    .shoot(shoot), .enemy_fire(enemyFire), .user_x(userX), .enemy_x(enemyX),
    .grid(grid), .player_shots(playerShots), .enemy_shots(enemyShots),
    .enemy_hit(enemyHit), .player_hit(playerHit), .hit_count(hitCount)
  );

  // 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a run that never ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] cellBit(input int c, input int r);
    logic [127:0] one;
    one = 128'd1;
    return one << (c * ROWS + r);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock with the given step / shoot level / enemy fire; sampled #1 after the edge.
  task automatic applyStimulus(input logic upd, input logic sh, input logic ef);
    gridUpdateEn = upd;
    shoot        = sh;
    enemyFire    = ef;
    tick();
    gridUpdateEn = 1'b0;
    enemyFire    = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int hits;
  int hitStep;
  logic [127:0] coolExp [4];

  initial begin
    reset = 1'b1; gridUpdateEn = 1'b0; shoot = 1'b0; enemyFire = 1'b0;
    userX = '0; enemyX = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_grid", grid, '0);
    checkOutput("reset_hit_count", hitCount, '0);
    checkOutput("reset_enemy_hit", enemyHit, '0);

    // Fire and travel: shot from column 3 rises to row 0, then leaves the field.
    userX = 4'd3; enemyX = 4'd5;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("travel_inject", playerShots, cellBit(3, 13));
    hits = 0;
    for (int s = 0; s < 13; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      hits += int'(enemyHit);
    end
    checkOutput("travel_row0", playerShots, cellBit(3, 0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    hits += int'(enemyHit);
    checkOutput("travel_dropped", grid, '0);
    checkOutput("travel_no_hit", hits, 0);

    // Enemy hits: 300 shots up column 3 into the enemy, score saturates at 255.
    userX = 4'd3; enemyX = 4'd3;
    hits = 0;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int s = 0; s < 11; s++) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        if (enemyHit) hits += 1000;
      end
      if (n == 0) checkOutput("ehit_at_row2", playerShots, cellBit(3, 2));
      applyStimulus(1'b1, 1'b0, 1'b0);
      hits += int'(enemyHit);
      if (n == 0) begin
        checkOutput("ehit_pulse", enemyHit, 1'b1);
        checkOutput("ehit_removed", playerShots, '0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ehit_pulse_end", enemyHit, 1'b0);
        checkOutput("ehit_count1", hitCount, 8'd1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ehit_pulses", hits, 300);
    checkOutput("ehit_saturate", hitCount, 8'd255);

    // Player hit: enemy shot from column 6 falls onto the player in column 6.
    userX = 4'd6; enemyX = 4'd6;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("phit_inject", enemyShots, cellBit(6, 2));
    hits = 0; hitStep = -1;
    for (int s = 1; s <= 14; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (playerHit) begin
        hits++;
        hitStep = s;
      end
    end
    checkOutput("phit_once", hits, 1);
    checkOutput("phit_step", hitStep, 12);
    checkOutput("phit_plane_empty", enemyShots, '0);
    checkOutput("phit_score_kept", hitCount, 8'd255);

    // Reset mid-flight with a coincident step, shoot and enemy fire.
    userX = 4'd2; enemyX = 4'd5;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("flight_grid", grid, cellBit(2, 11) | cellBit(5, 4));
    reset = 1'b1; gridUpdateEn = 1'b1; shoot = 1'b1; enemyFire = 1'b1;
    tick();
    reset = 1'b0; gridUpdateEn = 1'b0; shoot = 1'b0; enemyFire = 1'b0;
    checkOutput("rst_grid", grid, '0);
    checkOutput("rst_player", playerShots, '0);
    checkOutput("rst_enemy", enemyShots, '0);
    checkOutput("rst_pulses", {enemyHit, playerHit}, 2'b00);
    checkOutput("rst_score", hitCount, '0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_no_pending", grid, '0);

    // Cooldown: shoot edges before steps 0..3 inject only at steps 0 and 3.
    applyReset();
    userX = 4'd4; enemyX = 4'd0;
    coolExp[0] = cellBit(4, 13);
    coolExp[1] = cellBit(4, 12);
    coolExp[2] = cellBit(4, 11);
    coolExp[3] = cellBit(4, 10) | cellBit(4, 13);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("cool_step%0d", s), playerShots, coolExp[s]);
    end
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cool_pp_clear", playerShots, cellBit(4, 7) | cellBit(4, 10));

    // Cancellation, crossing: player (2,8) vs enemy (2,7).
    applyReset();
    userX = 4'd2; enemyX = 4'd2;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cancel1_pre", grid, cellBit(2, 8) | cellBit(2, 7));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cancel1_post", grid, '0);

    // Cancellation, would meet: player (2,8) vs enemy (2,6).
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cancel2_pre", grid, cellBit(2, 8) | cellBit(2, 6));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cancel2_post", grid, '0);

    // No cancellation at distance three: player (2,8), enemy (2,5) just move.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap3_pre", grid, cellBit(2, 8) | cellBit(2, 5));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap3_player", playerShots, cellBit(2, 7));
    checkOutput("gap3_enemy", enemyShots, cellBit(2, 6));

    // Out-of-range column: no shot and no cooldown, so the next valid shot goes at once.
    applyReset();
    userX = 4'd9;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("oor_no_inject", playerShots, '0);
    userX = 4'd2;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("oor_no_cooldown", playerShots, cellBit(2, 13));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
